cell_pos_reader: RTL and testbench

Read-side master for one cell position memory (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = packed {posz, posy, posx}). On a start pulse it fetches the count, then issues one read per particle and presents the words as a valid/ready stream with a last flag. It sits between a cell memory and the force-evaluation pipeline and is the only requester of that memory while busy.

---
 rtl/md_cell_pkg.sv | 22 ++
 rtl/cell_pos_reader_if.sv | 37 +++
 rtl/cell_rd_fifo.sv | 63 ++++++
 rtl/cell_pos_reader.sv | 192 +++++++++++++++++++
 tb/tb_cell_pos_reader.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/md_cell_pkg.sv
// Shared types and constants for the cell position read master.
// Contents:
//   state_e         FSM state encoding, also exported on the debug port
//   RD_FIFO_DEPTH   return-data FIFO depth and the read credit limit
//   MEM_RD_LATENCY  cycles from the rden cycle to valid mem_q
//   CNT_ADDR        address that holds the particle count
package md_cell_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CNT_REQ  = 3'd1,
    S_CNT_WAIT = 3'd2,
    S_STREAM   = 3'd3,
    S_DRAIN    = 3'd4,
    S_DONE     = 3'd5
  } state_e;

  localparam int RD_FIFO_DEPTH  = 4;
  localparam int MEM_RD_LATENCY = 2;
  localparam int CNT_ADDR       = 0;

endpackage

// File: rtl/cell_pos_reader_if.sv
// Bus bundle for cell_pos_reader: memory read port plus downstream stream.
// Modports:
//   master  the reader side (drives address/rden and the output stream)
//   slave   the memory + consumer side (drives mem_q and out_ready)
// Stream handshake: a word transfers on a rising edge where out_valid and
// out_ready are both high; once out_valid rises, out_data/out_index/out_last
// hold steady until that transfer happens.
interface cell_pos_reader_if #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 8
);
  logic [ADDR_WIDTH-1:0] mem_address;
  logic                  mem_rden;
  logic                  mem_wren;
  logic [DATA_WIDTH-1:0] mem_data;
  logic [DATA_WIDTH-1:0] mem_q;

  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;
  logic [ADDR_WIDTH-1:0] out_index;

  modport master (
    output mem_address, mem_rden, mem_wren, mem_data,
    input  mem_q,
    output out_data, out_valid, out_last, out_index,
    input  out_ready
  );

  modport slave (
    input  mem_address, mem_rden, mem_wren, mem_data,
    output mem_q,
    input  out_data, out_valid, out_last, out_index,
    output out_ready
  );
endinterface

// File: rtl/cell_rd_fifo.sv
// Small synchronous FIFO holding returned memory words with their address.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   push, push_data     write one entry (caller guarantees not full)
//   pop                 remove head entry (caller guarantees not empty)
//   head_data           current head entry
//   empty, count        occupancy status
module cell_rd_fifo
  import md_cell_pkg::*;
#(
  parameter int WIDTH = 104
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [WIDTH-1:0]               push_data,
  input  logic                           pop,
  output logic [WIDTH-1:0]               head_data,
  output logic                           empty,
  output logic [$clog2(RD_FIFO_DEPTH):0] count
);
  localparam int PW = $clog2(RD_FIFO_DEPTH);

  logic [WIDTH-1:0] slot_q [RD_FIFO_DEPTH];
  logic [WIDTH-1:0] slot_d [RD_FIFO_DEPTH];
  logic [PW-1:0]    wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]      cnt_q, cnt_d;

  always_comb begin
    slot_d = slot_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    if (push) begin
      slot_d[wr_q] = push_data;
      wr_d         = wr_q + 1'b1;
    end
    if (pop) rd_d = rd_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < RD_FIFO_DEPTH; i++) slot_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      slot_q <= slot_d;
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_data = slot_q[rd_q];
  assign empty     = (cnt_q == '0);
  assign count     = cnt_q;
endmodule

// File: rtl/cell_pos_reader.sv
// Read-side master for one cell position memory. On start it reads the
// particle count from address 0, then reads addresses 1..count and streams
// the words downstream with their address and a last flag.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           request to stream the cell (accepted only when idle)
//   busy, done      activity flag and one-cycle completion pulse
//   particle_count  count latched from address 0
//   count_err       sticky out-of-range count flag
//   dbg_state       current FSM state
//   bus             memory read port and output stream (master modport)
// Build option: CELL_RD_BOUNDS_CHECK_EN clamps an oversized count to
// PARTICLE_NUM-1 and raises count_err; without it the count is used as read.
module cell_pos_reader
  import md_cell_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int PARTICLE_NUM = 220,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic                  count_err,
  output state_e                dbg_state,
  cell_pos_reader_if.master     bus
);
  localparam int EW = DATA_WIDTH + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] CNT_A = ADDR_WIDTH'(CNT_ADDR);

  if (PARTICLE_NUM > (1 << ADDR_WIDTH)) begin : g_cfg_check
    $error("PARTICLE_NUM does not fit in ADDR_WIDTH");
  end

  state_e                state_q, state_d;
  logic                  rden_q, rden_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] next_q, next_d;
  logic [ADDR_WIDTH-1:0] pcount_q, pcount_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  // Two-stage shadow of rden/address: stage 2 lines up with valid mem_q.
  logic                  rd1_q, rd1_d, rd2_q, rd2_d;
  logic [ADDR_WIDTH-1:0] a1_q, a1_d, a2_q, a2_d;

  logic                           push, pop, fifo_empty;
  logic [EW-1:0]                  head;
  logic [$clog2(RD_FIFO_DEPTH):0] fifo_count;
  logic [ADDR_WIDTH-1:0]          head_addr, cnt_raw;
  logic [3:0]                     occ;
  logic                           credit_ok;

  assign head_addr = head[EW-1:DATA_WIDTH];
  assign pop       = !fifo_empty && bus.out_ready;
  assign push      = rd2_q && (a2_q != CNT_A);
  assign cnt_raw   = bus.mem_q[ADDR_WIDTH-1:0];

  // Entries the FIFO will have to absorb if another read is issued now:
  // current contents minus this cycle's pop, plus every read on the bus or
  // in the latency pipe. Keeping this below the depth makes overflow
  // impossible whatever out_ready does.
  assign occ       = 4'(fifo_count) + 4'(rden_q) + 4'(rd1_q) + 4'(rd2_q) - 4'(pop);
  assign credit_ok = occ < 4'(RD_FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    rden_d   = 1'b0;
    addr_d   = addr_q;
    next_d   = next_q;
    pcount_d = pcount_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = err_q;
    rd1_d    = rden_q;
    a1_d     = addr_q;
    rd2_d    = rd1_q;
    a2_d     = a1_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CNT_REQ;
          busy_d  = 1'b1;
          err_d   = 1'b0;
          rden_d  = 1'b1;
          addr_d  = CNT_A;
        end
      end
      S_CNT_REQ: state_d = S_CNT_WAIT;
      S_CNT_WAIT: begin
        // The count read reaches stage 2 exactly when its data is valid.
        if (rd2_q) begin
          pcount_d = cnt_raw;
`ifdef CELL_RD_BOUNDS_CHECK_EN
          if (cnt_raw > ADDR_WIDTH'(PARTICLE_NUM - 1)) begin
            pcount_d = ADDR_WIDTH'(PARTICLE_NUM - 1);
            err_d    = 1'b1;
          end
`endif
          if (pcount_d == '0) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            rden_d  = 1'b1;
            addr_d  = ADDR_WIDTH'(1);
            next_d  = ADDR_WIDTH'(2);
            state_d = (pcount_d == ADDR_WIDTH'(1)) ? S_DRAIN : S_STREAM;
          end
        end
      end
      S_STREAM: begin
        if (credit_ok) begin
          rden_d = 1'b1;
          addr_d = next_q;
          next_d = next_q + 1'b1;
          if (next_q == pcount_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Returns are in address order, so popping the last word means
        // nothing is left in flight or queued.
        if (pop && (head_addr == pcount_q)) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rden_q   <= 1'b0;
      addr_q   <= '0;
      next_q   <= '0;
      pcount_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      rd1_q    <= 1'b0;
      rd2_q    <= 1'b0;
      a1_q     <= '0;
      a2_q     <= '0;
    end else begin
      state_q  <= state_d;
      rden_q   <= rden_d;
      addr_q   <= addr_d;
      next_q   <= next_d;
      pcount_q <= pcount_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rd1_q    <= rd1_d;
      rd2_q    <= rd2_d;
      a1_q     <= a1_d;
      a2_q     <= a2_d;
    end
  end

  cell_rd_fifo #(.WIDTH(EW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data ({a2_q, bus.mem_q}),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign bus.mem_address = addr_q;
  assign bus.mem_rden    = rden_q;
  assign bus.mem_wren    = 1'b0;
  assign bus.mem_data    = '0;
  assign bus.out_valid   = !fifo_empty;
  assign bus.out_data    = head[DATA_WIDTH-1:0];
  assign bus.out_index   = head_addr;
  assign bus.out_last    = !fifo_empty && (head_addr == pcount_q);

  assign busy           = busy_q;
  assign done           = done_q;
  assign particle_count = pcount_q;
  assign count_err      = err_q;
  assign dbg_state      = state_q;
endmodule

// File: tb/tb_cell_pos_reader.sv
// Bench for cell_pos_reader: behavioural 2-cycle-latency memory, expected
// word queue built straight from memory contents, cycle-indexed checks of
// latency, ordering, hold-while-stalled and read-credit behaviour.
module tb_cell_pos_reader;
  import md_cell_pkg::*;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int EW = 1 + AW + DW;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy, done, count_err;
  logic [AW-1:0] particle_count;
  state_e dbg_state;

  cell_pos_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cell_pos_reader #(.DATA_WIDTH(DW), .PARTICLE_NUM(PN), .ADDR_WIDTH(AW)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .particle_count (particle_count),
    .count_err      (count_err),
    .dbg_state      (dbg_state),
    .bus            (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- memory model ----------------
  logic [DW-1:0] mem [256];
  logic [AW-1:0] s1_addr = '0;
  always @(posedge clk) begin
    s1_addr    <= bus.mem_address;
    bus.mem_q  <= mem[s1_addr];
  end

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int first_valid, done_cyc, issued, accepted, reads_20;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_cell(input int n, input int mode, input int budget);
    int exp_n;
    logic exp_err;
    logic [DW-1:0] w;
    logic [EW-1:0] e;
    logic r, hold;
    logic [EW:0] held;
    exp_n   = n;
    exp_err = 1'b0;
`ifdef CELL_RD_BOUNDS_CHECK_EN
    if (n > PN - 1) begin
      exp_n   = PN - 1;
      exp_err = 1'b1;
    end
`endif
    mem[0] = DW'(n);
    exp_q.delete();
    for (int i = 1; i <= exp_n; i++) begin
      w = {$urandom, $urandom, $urandom};
      mem[i] = w;
      exp_q.push_back({(i == exp_n), AW'(i), w});
    end
    first_valid = -1; done_cyc = -1; issued = 0; accepted = 0; reads_20 = 0;
    hold = 1'b0; held = '0;

    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      if (k > 1) @(negedge clk);
      if (k == 1)
        chk("count_req", {busy, bus.mem_rden, bus.mem_address}, {1'b1, 1'b1, AW'(0)});
      if (bus.mem_rden && bus.mem_address != 0) begin
        issued++;
        if (k <= 20) reads_20++;
        chk("credit", (issued - accepted) <= 4, 1);
      end
      if (hold)
        chk("hold_stable", {bus.out_valid, bus.out_last, bus.out_index, bus.out_data}, held);
      case (mode)
        0:       r = 1'b1;
        1:       r = (k % 2) == 1;
        2:       r = (k > 20);
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.out_ready = r;
      if (bus.out_valid && first_valid < 0) first_valid = k;
      hold = bus.out_valid && !r;
      held = {bus.out_valid, bus.out_last, bus.out_index, bus.out_data};
      if (bus.out_valid && r) begin
        total++;
        assert (exp_q.size() != 0) else begin
          bad++;
          $error("FAIL extra_word: got index %0d expected no word", bus.out_index);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("word", {bus.out_last, bus.out_index, bus.out_data}, e);
        end
        accepted++;
      end
      if (done) begin
        done_cyc = k;
        break;
      end
    end
    chk("done_seen", done_cyc >= 0, 1);
    chk("all_words", exp_q.size(), 0);
    chk("accepted", accepted, exp_n);
    if (mode == 0) begin
      chk("done_cycle", done_cyc, (exp_n == 0) ? 4 : 7 + exp_n);
      chk("first_valid", first_valid, (exp_n == 0) ? -1 : 7);
    end
    if (mode == 2) chk("stall_reads", reads_20, (exp_n < 4) ? exp_n : 4);
    @(negedge clk);
    chk("after_done", {done, busy, bus.out_valid}, 3'b000);
    chk("pcount", particle_count, exp_n);
    chk("count_err", count_err, exp_err);
    bus.out_ready = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst = 1'b1;
    start = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outputs",
        {busy, done, particle_count, count_err, bus.mem_rden, bus.mem_wren,
         bus.mem_address, bus.out_valid, bus.out_last, bus.out_index, bus.out_data},
        '0);
    chk("reset_state", dbg_state, S_IDLE);
    rst = 1'b0;
    @(negedge clk);

    run_cell(3, 0, 40);   // basic latency
    run_cell(0, 0, 20);   // empty cell
    run_cell(1, 0, 30);   // single word
    run_cell(10, 1, 80);  // toggling ready
    run_cell(8, 2, 100);  // long stall then release

    // reset while streaming
    mem[0] = DW'(6);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outputs",
        {busy, done, particle_count, count_err, bus.mem_rden, bus.mem_address,
         bus.out_valid, bus.out_last, bus.out_index, bus.out_data},
        '0);
    rst = 1'b0;
    @(negedge clk);
    run_cell(2, 0, 30);

    for (int t = 0; t < 4; t++) run_cell($urandom_range(1, 12), 3, 120);

`ifdef CELL_RD_BOUNDS_CHECK_EN
    run_cell(250, 0, 400);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
